adc_sample_sequencer: RTL and testbench

//  Sequences one parallel-output ADC (AD7886 class) at a fixed sample rate derived from the system clock.

---
 rtl/adc_seq_pkg.sv | 28 ++
 rtl/adc_rate_tick.sv | 38 +++
 rtl/adc_sample_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the AD7886-class ADC sample sequencer:
// default timing constants, the sequencer state encoding and a small helper.
package adc_seq_pkg;

  // Default timing, in clk cycles at 50 MHz.
  localparam int DEF_DIV_N   = 1563;  // sample period (~32 kHz)
  localparam int DEF_CONV_W  = 4;     // CONVST low pulse width
  localparam int DEF_RD_W    = 3;     // RD low width before the data word is captured
  localparam int DEF_DATA_W  = 12;    // ADC word width
  localparam int DEF_BUSY_TO = 256;   // max wait on each BUSY edge (timeout build only)

  // Sequencer state encoding.
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 3'd0;  // waiting for the next sample tick
  localparam state_t S_CONV    = 3'd1;  // CONVST held low
  localparam state_t S_WAIT_HI = 3'd2;  // waiting for BUSY to rise
  localparam state_t S_WAIT_LO = 3'd3;  // waiting for BUSY to fall (conversion done)
  localparam state_t S_READ    = 3'd4;  // CS/RD held low, data captured on the last cycle
  localparam state_t S_DONE    = 3'd5;  // strobes released, word handed downstream

  // Larger of two integers, used to size the shared pulse-width counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_rate_tick.sv
// Sample-period tick generator. Counts 0..DIV_N-1 in the clk domain and
// raises tick for one cycle on the terminal count. This replaces a divided
// sample clock: everything downstream stays on clk and uses tick as an enable.
// en=0 parks the counter at 0 so the first period after enabling is full length.
module adc_rate_tick
  import adc_seq_pkg::*;
#(
  parameter int DIV_N = DEF_DIV_N
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                 CNT_W = $clog2(DIV_N);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIV_N - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter: wraps at DIV_N-1, held at zero while sampling is disabled.
  // NOTE: state registers are always written with <= so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer for a parallel-output AD7886-class converter.
// Every DIV_N clk cycles it pulses CONVST, follows BUSY through a 2-flop
// synchronizer, strobes CS/RD, captures the word and offers it downstream on
// a valid/ready handshake. A word completed while the previous one is still
// unaccepted overwrites it and sets the sticky overrun flag.
//
// Build option: define ADC_TIMEOUT_EN to bound each BUSY wait to BUSY_TO
// cycles; on expiry the conversion is abandoned and timeout_err is set.
// Without it the waits are unbounded and timeout_err is tied low.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DIV_N   = DEF_DIV_N,
  parameter int CONV_W  = DEF_CONV_W,
  parameter int RD_W    = DEF_RD_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              adc_convst_n,
  input  logic              adc_busy,
  output logic              adc_cs_n,
  output logic              adc_rd_n,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              overrun,
  output logic              timeout_err
);

  // One counter times both the CONVST pulse and the RD strobe.
  localparam int PW = $clog2(max2(CONV_W, RD_W) + 1);

  logic              tick;
  logic              busy_meta;
  logic              busy_s;
  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [DATA_W-1:0] cap_data;
  logic              publish;
  logic              to_hit;

  adc_rate_tick #(
    .DIV_N (DIV_N)
  ) u_rate_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Bring the asynchronous BUSY into the clk domain.
  // NOTE: nothing but a plain flop may sit between the two stages; the first
  // stage may go metastable and is given a full cycle to settle before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= adc_busy;
      busy_s    <= busy_meta;
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TO + 1);

  logic [TW-1:0] to_cnt;
  logic          wait_stall;

  // Still waiting for the BUSY edge the current state expects.
  assign wait_stall = ((state == S_WAIT_HI) && !busy_s) ||
                      ((state == S_WAIT_LO) &&  busy_s);
  // This is the BUSY_TO-th cycle of the current wait with no edge seen.
  assign to_hit     = wait_stall && (to_cnt == TW'(BUSY_TO - 1));

  // Length of the current BUSY wait; restarts whenever the wait ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (wait_stall) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Sticky record that a conversion was abandoned for lack of a BUSY edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (to_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  localparam int busy_to_unused = BUSY_TO;

  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Conversion sequence; ADC strobes are registered so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pcnt         <= '0;
      adc_convst_n <= 1'b1;
      adc_cs_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      cap_data     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Ticks seen in any other state are dropped, so a slow ADC never
          // stretches the sample period.
          if (tick) begin
            state        <= S_CONV;
            pcnt         <= '0;
            adc_convst_n <= 1'b0;
          end
        end

        S_CONV: begin
          if (pcnt == PW'(CONV_W - 1)) begin
            adc_convst_n <= 1'b1;
            state        <= S_WAIT_HI;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end

        S_WAIT_HI: begin
          if (busy_s) begin
            state <= S_WAIT_LO;
          end else if (to_hit) begin
            state <= S_IDLE;
          end
        end

        S_WAIT_LO: begin
          if (!busy_s) begin
            state    <= S_READ;
            pcnt     <= '0;
            adc_cs_n <= 1'b0;
            adc_rd_n <= 1'b0;
          end else if (to_hit) begin
            state    <= S_IDLE;
            adc_cs_n <= 1'b1;
            adc_rd_n <= 1'b1;
          end
        end

        S_READ: begin
          // Capture while RD is still low, then release both strobes.
          if (pcnt == PW'(RD_W - 1)) begin
            cap_data <= adc_data;
            adc_cs_n <= 1'b1;
            adc_rd_n <= 1'b1;
            state    <= S_DONE;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        // NOTE: the two unused encodings recover to a safe idle with the
        // ADC strobes released instead of leaving the FSM stranded.
        default: begin
          state        <= S_IDLE;
          adc_convst_n <= 1'b1;
          adc_cs_n     <= 1'b1;
          adc_rd_n     <= 1'b1;
        end
      endcase
    end
  end

  // The captured word is handed downstream in the single DONE cycle.
  assign publish = (state == S_DONE);

  // Output word and valid: a new word always loads, otherwise valid clears on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_data  <= '0;
      smp_valid <= 1'b0;
    end else if (publish) begin
      smp_data  <= cap_data;
      smp_valid <= 1'b1;
    end else if (smp_valid && smp_ready) begin
      smp_valid <= 1'b0;
    end
  end

  // Sticky overrun: a word was replaced before downstream accepted it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (publish && smp_valid && !smp_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer with a short sample period.
// A behavioural ADC answers each CONVST with a BUSY pulse and a random word;
// the words queue up in order and every accepted sample must match the queue
// head. Directed phases cover reset, overrun, accept-on-publish, disable
// mid-conversion, reset mid-read and (with ADC_TIMEOUT_EN) the BUSY timeout.
module tb_adc_sample_sequencer;

  localparam int DIV_N    = 64;
  localparam int CONV_W   = 4;
  localparam int RD_W     = 3;
  localparam int DATA_W   = 12;
  localparam int BUSY_TO  = 256;
  localparam int BUSY_LEN = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              adc_busy = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              smp_ready = 1'b0;
  logic              adc_convst_n;
  logic              adc_cs_n;
  logic              adc_rd_n;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              overrun;
  logic              timeout_err;

  adc_sample_sequencer #(
    .DIV_N   (DIV_N),
    .CONV_W  (CONV_W),
    .RD_W    (RD_W),
    .DATA_W  (DATA_W),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .adc_convst_n (adc_convst_n),
    .adc_busy     (adc_busy),
    .adc_cs_n     (adc_cs_n),
    .adc_rd_n     (adc_rd_n),
    .adc_data     (adc_data),
    .smp_data     (smp_data),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- Behavioural ADC ----------------
  int                busy_left  = 0;
  bit                busy_stuck = 1'b0;
  bit                fixed_en   = 1'b0;
  logic [DATA_W-1:0] fixed_word = '0;
  logic [DATA_W-1:0] model_word;
  logic              adc_cv_prev = 1'b1;
  logic [DATA_W-1:0] word_q[$];

  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        model_word = fixed_en ? fixed_word : DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        adc_busy   = 1'b0;
        adc_data   = model_word;
        word_q.push_back(model_word);
      end
    end else if (adc_cv_prev && !adc_convst_n && !busy_stuck) begin
      adc_busy  = 1'b1;
      busy_left = BUSY_LEN;
    end
    adc_cv_prev = adc_convst_n;
  end

  function automatic logic [DATA_W-1:0] q_at(input int i);
    return (i < word_q.size()) ? word_q[i] : 'x;
  endfunction

  // ---------------- Monitor and scoreboard ----------------
  int   cyc       = 0;
  bit   mon_en    = 1'b0;
  bit   sb_en     = 1'b0;
  int   low_run   = 0;
  int   rd_run    = 0;
  int   last_fall = -1;
  int   falls     = 0;
  int   delivered = 0;
  logic cv_prev   = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (cv_prev && !adc_convst_n) begin
      falls++;
      if (mon_en) begin
        if (last_fall >= 0) check("sample period", cyc - last_fall, DIV_N);
        last_fall = cyc;
      end
    end
    cv_prev = adc_convst_n;
    if (mon_en) begin
      if (!adc_convst_n) low_run++;
      else if (low_run > 0) begin
        check("convst_n low width", low_run, CONV_W);
        low_run = 0;
      end
      if (!adc_rd_n) rd_run++;
      else if (rd_run > 0) begin
        check("rd_n low width", rd_run, RD_W);
        rd_run = 0;
      end
    end
    if (sb_en && smp_valid && smp_ready) begin
      check("accepted smp_data", smp_data, q_at(0));
      if (word_q.size() > 0) void'(word_q.pop_front());
      delivered++;
    end
  end

  // Wait (bounded) until a selected output reaches a level; records reach as a check.
  // sel: 0 convst_n, 1 rd_n, 2 adc_busy, 3 smp_valid
  task automatic wait_sig(input int sel, input logic lvl, input int budget, input string tag);
    logic cur;
    int   n;
    n = 0;
    forever begin
      case (sel)
        0:       cur = adc_convst_n;
        1:       cur = adc_rd_n;
        2:       cur = adc_busy;
        default: cur = smp_valid;
      endcase
      if (cur == lvl || n >= budget) break;
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cur == lvl), 1);
  endtask

  task automatic wait_words(input int cnt, input int budget, input string tag);
    int n;
    n = 0;
    while (word_q.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(word_q.size() >= cnt), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " convst_n"},    adc_convst_n, 1);
    check({pfx, " cs_n"},        adc_cs_n,     1);
    check({pfx, " rd_n"},        adc_rd_n,     1);
    check({pfx, " smp_data"},    smp_data,     0);
    check({pfx, " smp_valid"},   smp_valid,    0);
    check({pfx, " overrun"},     overrun,      0);
    check({pfx, " timeout_err"}, timeout_err,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  f0;
    int  n;
    bit  saw_valid;

    // ---- Reset values ----
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // en=0: counter parked, no conversion may start.
    f0 = falls;
    repeat (2 * DIV_N) @(negedge clk);
    check("no convst while disabled", falls - f0, 0);

    // ---- Free-running sampling, downstream always ready ----
    last_fall = -1;
    delivered = 0;
    mon_en    = 1'b1;
    sb_en     = 1'b1;
    smp_ready = 1'b1;
    en        = 1'b1;
    repeat (8 * DIV_N + 50) @(negedge clk);
    check("samples delivered", delivered, 8);
    check("no words left undelivered", word_q.size(), 0);
    check("no overrun when ready", overrun, 0);
    check("no timeout in normal run", timeout_err, 0);

    // ---- Overrun: downstream stalls for two periods ----
    sb_en     = 1'b0;
    smp_ready = 1'b0;
    word_q.delete();
    wait_words(1, 2 * DIV_N, "first stalled word produced");
    fixed_en   = 1'b1;
    fixed_word = 12'hA5C;
    repeat (20) @(negedge clk);
    check("stalled valid", smp_valid, 1);
    check("stalled data", smp_data, q_at(0));
    check("single word no overrun", overrun, 0);
    wait_words(2, 2 * DIV_N, "second stalled word produced");
    repeat (20) @(negedge clk);
    check("overrun valid held", smp_valid, 1);
    check("overrun set", overrun, 1);
    check("overrun data is newest", smp_data, 12'hA5C);
    fixed_en  = 1'b0;
    smp_ready = 1'b1;
    @(negedge clk);
    check("valid drops after accept", smp_valid, 0);
    check("overrun sticky", overrun, 1);

    // ---- Reset pulse during READ ----
    mon_en    = 1'b0;
    smp_ready = 1'b0;
    wait_sig(1, 1'b0, 2 * DIV_N, "rd_n low (hold sample)");
    wait_sig(1, 1'b1, 2 * DIV_N, "rd_n high (hold sample)");
    wait_sig(1, 1'b0, 2 * DIV_N, "rd_n low (reset target)");
    check("held sample valid before reset", smp_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset in READ");
    repeat (2) @(negedge clk);
    word_q.delete();
    rst = 1'b0;
    n         = 0;
    saw_valid = 1'b0;
    while (adc_convst_n && n < 2 * DIV_N) begin
      @(negedge clk);
      n++;
      if (smp_valid) saw_valid = 1'b1;
    end
    check("first convst after reset is a full period", n, DIV_N);
    check("no sample emitted after reset", saw_valid, 0);

    // ---- Publish coinciding with accept of previous word ----
    wait_sig(3, 1'b1, 2 * DIV_N, "first word valid");
    check("first word data", smp_data, q_at(0));
    wait_sig(1, 1'b0, 2 * DIV_N, "second read starts");
    wait_sig(1, 1'b1, 2 * DIV_N, "second read ends");
    smp_ready = 1'b1;  // DONE cycle: accept old word while the new one loads
    @(negedge clk);
    check("coincident publish valid", smp_valid, 1);
    check("coincident publish data", smp_data, q_at(1));
    check("coincident publish no overrun", overrun, 0);
    @(negedge clk);
    check("coincident word accepted", smp_valid, 0);

    // ---- en dropped while waiting for BUSY to fall ----
    word_q.delete();
    delivered = 0;
    sb_en     = 1'b1;
    wait_sig(2, 1'b1, 2 * DIV_N, "busy rises");
    repeat (10) @(negedge clk);
    en = 1'b0;
    f0 = falls;
    repeat (3 * DIV_N) @(negedge clk);
    check("in-flight sample delivered", delivered, 1);
    check("no convst after disable", falls - f0, 0);
    check("convst_n idle after disable", adc_convst_n, 1);
    check("cs_n idle after disable", adc_cs_n, 1);
    sb_en = 1'b0;

`ifdef ADC_TIMEOUT_EN
    // ---- BUSY stuck low: WAIT_HI times out ----
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    busy_stuck = 1'b1;
    en         = 1'b1;
    wait_sig(0, 1'b0, 2 * DIV_N, "timeout convst low");
    wait_sig(0, 1'b1, 2 * CONV_W, "timeout convst high");
    f0        = falls;
    saw_valid = 1'b0;
    repeat (BUSY_TO - 1) begin
      @(negedge clk);
      if (smp_valid) saw_valid = 1'b1;
    end
    check("timeout_err before limit", timeout_err, 0);
    @(negedge clk);
    check("timeout_err at limit", timeout_err, 1);
    check("ticks dropped while waiting", falls - f0, 0);
    check("no sample on timeout", saw_valid, 0);
    check("cs_n released on timeout", adc_cs_n, 1);
    wait_sig(0, 1'b0, DIV_N + 2, "conversion restarts after timeout");
    busy_stuck = 1'b0;
`else
    check("timeout_err tied low", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
